// File: rtl/bomb_pkg.sv
// ============================================================================
// Module      : bomb_pkg
// Description : Shared types and constants for the bomb controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bomb_pkg;

    localparam int TILE_W = 4;
    localparam int CNT_W  = 8;

    localparam logic [7:0] KEY_P1_BOMB = 8'h19;
    localparam logic [7:0] KEY_P2_BOMB = 8'h13;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_FUSE   = 3'd1,
        PH_EXP_S  = 3'd2,
        PH_EXP_L  = 3'd3,
        PH_EXP_S2 = 3'd4
    } bomb_phase_t;

endpackage

`default_nettype wire

// File: rtl/bomb_timer.sv
// ============================================================================
// Module      : bomb_timer
// Description : One bomb's phase FSM, frame counter, tile latch and blast flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bomb_timer
    import bomb_pkg::*;
#(
    parameter int FUSE_FRAMES = 120,
    parameter int EXP_FRAMES  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              place,
    input  logic              tick_en,
    input  logic              clear_pending,
    input  logic [TILE_W-1:0] x,
    input  logic [TILE_W-1:0] y,
    output logic [2:0]        phase,
    output logic [TILE_W-1:0] bx,
    output logic [TILE_W-1:0] by,
    output logic              pending
);

    localparam logic [CNT_W-1:0] C_FUSE_LOAD = CNT_W'(FUSE_FRAMES - 1);
    localparam logic [CNT_W-1:0] C_EXP_LOAD  = CNT_W'(EXP_FRAMES - 1);

    bomb_phase_t       phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TILE_W-1:0] bx_q, bx_d;
    logic [TILE_W-1:0] by_q, by_d;
    logic              pending_q, pending_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= PH_IDLE;
            cnt_q     <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            pending_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        bx_d      = bx_q;
        by_d      = by_q;
        pending_d = pending_q & ~clear_pending;

        case (phase_q)
            PH_IDLE: begin
                if (place) begin
                    phase_d = PH_FUSE;
                    cnt_d   = C_FUSE_LOAD;
                    bx_d    = x;
                    by_d    = y;
                end
            end
            PH_FUSE, PH_EXP_S, PH_EXP_L, PH_EXP_S2: begin
                if (tick_en) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        cnt_d = C_EXP_LOAD;
                        case (phase_q)
                            PH_FUSE: begin
                                phase_d   = PH_EXP_S;
                                pending_d = 1'b1;
                            end
                            PH_EXP_S: phase_d = PH_EXP_L;
                            PH_EXP_L: phase_d = PH_EXP_S2;
                            default: begin
                                phase_d = PH_IDLE;
                                cnt_d   = '0;
                            end
                        endcase
                    end
                end
            end
            // Unreachable encodings fall back to a clean idle bomb.
            default: begin
                phase_d = PH_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign phase   = phase_q;
    assign bx      = bx_q;
    assign by      = by_q;
    assign pending = pending_q;

endmodule

`default_nettype wire

// File: rtl/bomb_controller.sv
// ============================================================================
// Module      : bomb_controller
// Description : Two-player bomb sequencing with round-robin blast announcement.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bomb_controller
    import bomb_pkg::*;
#(
    parameter logic [7:0] P1_KEY      = KEY_P1_BOMB,
    parameter logic [7:0] P2_KEY      = KEY_P2_BOMB,
    parameter int         FUSE_FRAMES = 120,
    parameter int         EXP_FRAMES  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic              game_active,
    input  logic [7:0]        keycode,
    input  logic [TILE_W-1:0] p1_x,
    input  logic [TILE_W-1:0] p1_y,
    input  logic [TILE_W-1:0] p2_x,
    input  logic [TILE_W-1:0] p2_y,
    output logic [2:0]        b1_phase,
    output logic [2:0]        b2_phase,
    output logic [TILE_W-1:0] b1_x,
    output logic [TILE_W-1:0] b1_y,
    output logic [TILE_W-1:0] b2_x,
    output logic [TILE_W-1:0] b2_y,
    output logic              blast_valid,
    output logic              blast_owner,
    output logic [TILE_W-1:0] blast_x,
    output logic [TILE_W-1:0] blast_y
);

    logic [7:0]        prev_key_q;
    logic              rr_q, rr_d;
    logic              valid_q, valid_d;
    logic              owner_q, owner_d;
    logic [TILE_W-1:0] bl_x_q, bl_x_d;
    logic [TILE_W-1:0] bl_y_q, bl_y_d;

    logic tick_en, place1, place2;
    logic pend1, pend2, clr1, clr2;
    logic grant_any, grant_owner;

    assign tick_en = frame_tick & game_active;
    assign place1  = game_active && (keycode == P1_KEY) && (prev_key_q != P1_KEY)
                     && (b1_phase == PH_IDLE);
    assign place2  = game_active && (keycode == P2_KEY) && (prev_key_q != P2_KEY)
                     && (b2_phase == PH_IDLE);

    bomb_timer #(
        .FUSE_FRAMES (FUSE_FRAMES),
        .EXP_FRAMES  (EXP_FRAMES)
    ) u_timer_p1 (
        .clk           (Clk),
        .rst           (Reset),
        .place         (place1),
        .tick_en       (tick_en),
        .clear_pending (clr1),
        .x             (p1_x),
        .y             (p1_y),
        .phase         (b1_phase),
        .bx            (b1_x),
        .by            (b1_y),
        .pending       (pend1)
    );

    bomb_timer #(
        .FUSE_FRAMES (FUSE_FRAMES),
        .EXP_FRAMES  (EXP_FRAMES)
    ) u_timer_p2 (
        .clk           (Clk),
        .rst           (Reset),
        .place         (place2),
        .tick_en       (tick_en),
        .clear_pending (clr2),
        .x             (p2_x),
        .y             (p2_y),
        .phase         (b2_phase),
        .bx            (b2_x),
        .by            (b2_y),
        .pending       (pend2)
    );

    // The pointer names the bomb that wins a tie; it only moves on a tie.
    always_comb begin
        grant_any   = pend1 | pend2;
        grant_owner = (pend1 & pend2) ? rr_q : pend2;
        clr1        = grant_any & ~grant_owner;
        clr2        = grant_any & grant_owner;
        rr_d        = (pend1 & pend2) ? ~rr_q : rr_q;
        valid_d     = grant_any;
        owner_d     = owner_q;
        bl_x_d      = bl_x_q;
        bl_y_d      = bl_y_q;
        if (grant_any) begin
            owner_d = grant_owner;
            bl_x_d  = grant_owner ? b2_x : b1_x;
            bl_y_d  = grant_owner ? b2_y : b1_y;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_key_q <= 8'h00;
            rr_q       <= 1'b0;
            valid_q    <= 1'b0;
            owner_q    <= 1'b0;
            bl_x_q     <= '0;
            bl_y_q     <= '0;
        end else begin
            prev_key_q <= keycode;
            rr_q       <= rr_d;
            valid_q    <= valid_d;
            owner_q    <= owner_d;
            bl_x_q     <= bl_x_d;
            bl_y_q     <= bl_y_d;
        end
    end

    assign blast_valid = valid_q;
    assign blast_owner = owner_q;
    assign blast_x     = bl_x_q;
    assign blast_y     = bl_y_q;

endmodule

`default_nettype wire

// File: tb/tb_bomb_controller.sv
// ============================================================================
// Module      : tb_bomb_controller
// Description : Directed scoreboard bench for bomb_controller (FUSE=4, EXP=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bomb_controller;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       game_active = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic [3:0] p1_x = 4'd0, p1_y = 4'd0, p2_x = 4'd0, p2_y = 4'd0;
    logic [2:0] b1_phase, b2_phase;
    logic [3:0] b1_x, b1_y, b2_x, b2_y;
    logic       blast_valid, blast_owner;
    logic [3:0] blast_x, blast_y;

    typedef struct packed {
        logic       owner;
        logic [3:0] x;
        logic [3:0] y;
    } blast_t;

    blast_t exp_q[$];
    int     chk_cnt  = 0;
    int     pass_cnt = 0;

    bomb_controller #(
        .P1_KEY      (8'h19),
        .P2_KEY      (8'h13),
        .FUSE_FRAMES (4),
        .EXP_FRAMES  (2)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .game_active (game_active),
        .keycode     (keycode),
        .p1_x        (p1_x),
        .p1_y        (p1_y),
        .p2_x        (p2_x),
        .p2_y        (p2_y),
        .b1_phase    (b1_phase),
        .b2_phase    (b2_phase),
        .b1_x        (b1_x),
        .b1_y        (b1_y),
        .b2_x        (b2_x),
        .b2_y        (b2_y),
        .blast_valid (blast_valid),
        .blast_owner (blast_owner),
        .blast_x     (blast_x),
        .blast_y     (blast_y)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick_edge();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic tick();
        tick_edge();
        step();
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        keycode = 8'h00;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic push(input logic o, input logic [3:0] x, input logic [3:0] y);
        blast_t b;
        b.owner = o;
        b.x     = x;
        b.y     = y;
        exp_q.push_back(b);
    endtask

    // Monitor: every announced blast must match the oldest expected one.
    always @(negedge Clk) begin
        if (!Reset && blast_valid) begin
            if (exp_q.size() == 0) begin
                chk("blast_unexpected", 1, 0);
            end else begin
                blast_t e;
                e = exp_q.pop_front();
                chk("blast_owner", int'(blast_owner), int'(e.owner));
                chk("blast_x", int'(blast_x), int'(e.x));
                chk("blast_y", int'(blast_y), int'(e.y));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_b1_phase", b1_phase, 0);
        chk("rst_b2_phase", b2_phase, 0);
        chk("rst_b1_x", b1_x, 0);
        chk("rst_blast_valid", blast_valid, 0);

        // Placement, held key does not re-place or relatch
        p1_x = 4'd3; p1_y = 4'd5;
        keycode = 8'h19;
        step();
        chk("place_b1_phase", b1_phase, 1);
        chk("place_b1_x", b1_x, 3);
        chk("place_b1_y", b1_y, 5);
        p1_x = 4'd7; p1_y = 4'd7;
        step();
        step();
        chk("held_b1_x", b1_x, 3);
        chk("held_b2_phase", b2_phase, 0);
        keycode = 8'h00;
        step();

        // Fuse and explosion schedule
        repeat (3) tick();
        chk("fuse3_phase", b1_phase, 1);
        push(1'b0, 4'd3, 4'd5);
        tick_edge();
        chk("exp_s_phase", b1_phase, 2);
        step();
        tick();
        tick_edge();
        chk("exp_l_phase", b1_phase, 3);
        step();
        tick();
        tick_edge();
        chk("exp_s2_phase", b1_phase, 4);
        step();
        tick();
        keycode = 8'h19;
        tick_edge();
        chk("idle_press_ignored", b1_phase, 0);
        keycode = 8'h00;
        step();
        keycode = 8'h19;
        step();
        chk("fresh_press_phase", b1_phase, 1);
        chk("fresh_press_x", b1_x, 7);
        keycode = 8'h00;

        // Pause mid-fuse
        tick();
        game_active = 1'b0;
        repeat (25) tick();
        keycode = 8'h13;
        step();
        keycode = 8'h00;
        repeat (25) tick();
        chk("pause_b1_phase", b1_phase, 1);
        chk("pause_b2_phase", b2_phase, 0);
        game_active = 1'b1;
        tick();
        tick();
        chk("resume_fuse_phase", b1_phase, 1);
        push(1'b0, 4'd7, 4'd7);
        tick_edge();
        chk("resume_exp_s_phase", b1_phase, 2);
        step();
        repeat (6) tick();
        chk("resume_idle_phase", b1_phase, 0);

        // Simultaneous expiry, pointer from reset
        do_reset();
        p1_x = 4'd4; p1_y = 4'd6; p2_x = 4'd8; p2_y = 4'd10;
        keycode = 8'h19;
        step();
        keycode = 8'h13;
        step();
        keycode = 8'h00;
        step();
        repeat (3) tick();
        push(1'b0, 4'd4, 4'd6);
        push(1'b1, 4'd8, 4'd10);
        tick();
        chk("col1_first_valid", blast_valid, 1);
        chk("col1_first_owner", blast_owner, 0);
        step();
        chk("col1_second_valid", blast_valid, 1);
        chk("col1_second_owner", blast_owner, 1);
        step();
        chk("col1_after_valid", blast_valid, 0);
        repeat (6) tick();
        chk("col1_b2_idle", b2_phase, 0);

        // Second collision: pointer now favours player 2
        keycode = 8'h19;
        step();
        keycode = 8'h13;
        step();
        keycode = 8'h00;
        step();
        repeat (3) tick();
        push(1'b1, 4'd8, 4'd10);
        push(1'b0, 4'd4, 4'd6);
        tick();
        chk("col2_first_owner", blast_owner, 1);
        step();
        chk("col2_second_owner", blast_owner, 0);
        repeat (6) tick();

        // Reset while b1 in EXP_L and b2 has a fresh pending blast
        do_reset();
        p1_x = 4'd1; p1_y = 4'd1; p2_x = 4'd2; p2_y = 4'd2;
        keycode = 8'h19;
        step();
        keycode = 8'h00;
        step();
        tick();
        tick();
        keycode = 8'h13;
        step();
        keycode = 8'h00;
        step();
        tick();
        push(1'b0, 4'd1, 4'd1);
        tick();
        tick();
        tick_edge();
        chk("abort_pre_b1", b1_phase, 3);
        chk("abort_pre_b2", b2_phase, 2);
        Reset = 1'b1;
        step();
        chk("abort_b1_phase", b1_phase, 0);
        chk("abort_b2_phase", b2_phase, 0);
        chk("abort_valid", blast_valid, 0);
        Reset = 1'b0;
        repeat (5) step();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bomb_controller.md
Name: bomb_controller

Overview:
- Sequences the bomb lifecycle for both players: placement, fuse, the three-step explosion animation, and return to idle.
- Timers advance on the per-frame tick and freeze whenever the game is not in the Continue (play) state.
- Shares a single blast-announcement port, consumed by the collision/die logic that drives p1die/p2die, between the two bombs using round-robin arbitration.
- Sits between the keyboard keycode path, the game state machine, and the sprite/collision logic.

Parameters:
- P1_KEY, 8'h19, keycode that places player 1's bomb
- P2_KEY, 8'h13, keycode that places player 2's bomb
- FUSE_FRAMES, 120, frame ticks spent in FUSE (range 1..255)
- EXP_FRAMES, 16, frame ticks spent in each explosion phase (range 1..255)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- game_active  in  1  high while the game state machine is in Continue
- keycode  in  8  current USB keycode; 8'h00 when no key is pressed
- p1_x, p1_y  in  4 each  player 1 tile coordinates
- p2_x, p2_y  in  4 each  player 2 tile coordinates
- b1_phase, b2_phase  out  3 each  bomb phase code (see Behaviour)
- b1_x, b1_y, b2_x, b2_y  out  4 each  latched bomb tile coordinates
- blast_valid  out  1  one-cycle pulse announcing a detonation
- blast_owner  out  1  0 = player 1 bomb, 1 = player 2 bomb
- blast_x, blast_y  out  4 each  tile coordinates of the announced blast

Behaviour:
- Reset behaviour: all outputs are registered. Reset drives both phases to IDLE, all coordinates to 0, blast_* to 0, the round-robin pointer to favour P1, the previous-keycode register to 8'h00, and both counters to 0. Reset mid-explosion aborts the bomb and drops any pending blast.
- Phase codes: IDLE=0, FUSE=1, EXP_S=2 (small), EXP_L=3 (large), EXP_S2=4 (small). Codes 5..7 are illegal; the FSM recovers from them to IDLE.
- Placement:
  - A bomb is placed on the cycle where keycode==Pn_KEY and prev_keycode!=Pn_KEY (edge detect), game_active=1, and the bomb is in IDLE.
  - On the next edge the bomb enters FUSE, pn_x/pn_y are latched into bn_x/bn_y, and the counter is loaded with FUSE_FRAMES-1.
  - A held key does not re-place. A key press is ignored when the bomb is not IDLE, including the cycle in which the bomb returns to IDLE.
- Timing:
  - The counter decrements only on cycles where frame_tick=1 and game_active=1.
  - When the counter is 0 and that qualifying tick occurs, the bomb advances FUSE->EXP_S->EXP_L->EXP_S2->IDLE and the counter reloads with EXP_FRAMES-1.
  - Each non-idle phase therefore lasts exactly its parameter in qualifying ticks.
- Pause: game_active=0 freezes the phase, counter and coordinates. Pending blasts are still granted. No placement is accepted.
- Blast pending: entering EXP_S sets the bomb's pending flag on the same edge the phase changes.
- Arbitration:
  - On each edge where at least one pending flag is set, one bomb is granted: blast_valid=1 and blast_owner/x/y are driven for exactly one cycle, and the granted pending flag is cleared.
  - If both flags are set, the grant goes to the bomb not granted last and the pointer flips. The other bomb is granted on the following edge.
  - Latency: a tick sampled at edge E causes EXP_S after E and blast_valid high in the cycle after E+1 for the winner, and after E+2 for the loser.
- Simultaneous events: both bombs may expire on the same tick, which produces two consecutive blast pulses. A pending flag persists through pause and through the phase advancing past EXP_S.
- Width: the counters are 8-bit unsigned and never wrap, because a reload always occurs at 0.

Decomposition:
- Shared package bomb_pkg holds:
  - the bomb_phase_t enum (IDLE..EXP_S2, 3-bit)
  - default key constants KEY_P1_BOMB and KEY_P2_BOMB
  - the tile coordinate width TILE_W=4
- Sub-module bomb_timer, instantiated twice, holds one bomb's phase FSM, counter, coordinate latch and pending flag. Its inputs are place, tick_en, x and y; its outputs are phase, bx, by and pending, plus a clear_pending input.
- The top level holds the key edge detect, the round-robin arbiter and the blast output registers.

Test Plan:
- Reset, then keycode=8'h19 held for 3 cycles with game_active=1, p1=(3,5): b1_phase=1 one edge later and b1_x/y=3/5. No second placement occurs while the key is held. b2_phase stays 0.
- FUSE_FRAMES=4, EXP_FRAMES=2, P1 placed: after 4 ticks b1_phase=2 and a blast_valid pulse with owner=0 and (3,5). After 2, 4 and 6 further ticks b1_phase is 3, 4 and 0 respectively.
- Both bombs placed so that they expire on the same tick, with the pointer at reset: blast_valid high for 2 consecutive cycles, owner 0 then 1. Repeat the collision: owner order is 1 then 0.
- game_active=0 for 50 ticks mid-FUSE: b1_phase and the counter are unchanged. Key 8'h13 pressed during the pause is ignored. On resume the remaining fuse completes on schedule.
- Reset asserted during EXP_L with a blast pending: the next cycle shows all phases=0 and blast_valid=0, and no blast pulse follows.
- Key press on the cycle the bomb enters IDLE from EXP_S2 is ignored. A fresh press one cycle later places the bomb.
